// File: rtl/stopwatch_ctrl.sv
// Stopwatch control core: centisecond prescaler, BCD mm:ss:cc time register, run/stop/lap FSM
// and the display snapshot scheduler. Define STOPWATCH_LAP_EN to build in the lap register.
module stopwatch_ctrl #(
    parameter int unsigned TICK_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_start_stop,
    input  logic        btn_lap,
    input  logic        btn_clear,
    input  logic        disp_ack,
    output logic        disp_req,
    output logic [23:0] disp_digits,
    output logic        running,
    output logic        lap_hold,
    output logic        overflow
);

    localparam int unsigned   PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_STOP,
        ST_LAP_RUN
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [23:0]   time_q, time_d;
    logic          ovf_q, ovf_d;
    logic          pending_q, pending_d;
    logic          req_q, req_d;
    logic [23:0]   digits_q, digits_d;
`ifdef STOPWATCH_LAP_EN
    logic [23:0]   lap_q, lap_d;
`endif

    logic          is_running, tick, wrap, lap_pulse, clear_eff, issue, set_pend;
    logic [23:0]   src;

    // Increment a packed {m1,m0,s1,s0,c1,c0} BCD value; the MSB of the result flags 59:59:99 -> 0.
    function automatic logic [24:0] bcd_inc(input logic [23:0] t);
        logic [23:0] n;
        logic        carry;
        logic [3:0]  lim;
        n     = t;
        carry = 1'b1;
        for (int i = 0; i < 6; i++) begin
            lim = (i == 3 || i == 5) ? 4'd5 : 4'd9;
            if (carry) begin
                if (n[i*4 +: 4] == lim) begin
                    n[i*4 +: 4] = 4'd0;
                end else begin
                    n[i*4 +: 4] = n[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return {carry, n};
    endfunction

    assign lap_pulse = LAP_EN && btn_lap;

    always_comb begin
        // NOTE: every signal gets its hold value first so no path can infer a latch.
        state_d   = state_q;
        presc_d   = presc_q;
        time_d    = time_q;
        ovf_d     = ovf_q;
        pending_d = pending_q;
        req_d     = req_q;
        digits_d  = digits_q;
        wrap      = 1'b0;
`ifdef STOPWATCH_LAP_EN
        lap_d     = lap_q;
        src       = (state_q == ST_LAP_RUN) ? lap_q : time_q;
`else
        src       = time_q;
`endif

        is_running = (state_q == ST_RUN) || (state_q == ST_LAP_RUN);
        tick       = is_running && (presc_q == PRESC_MAX);
        clear_eff  = (state_q == ST_STOP) && btn_clear;

        if (is_running) presc_d = tick ? '0 : presc_q + PW'(1);
        if (tick) begin
            {wrap, time_d} = bcd_inc(time_q);
            if (wrap) ovf_d = 1'b1;
        end

        // Only the highest-priority pulse that acts in the current state is honoured.
        unique case (state_q)
            ST_IDLE: if (btn_start_stop) state_d = ST_RUN;
            ST_RUN: begin
                if (btn_start_stop) begin
                    state_d = ST_STOP;
                end else if (lap_pulse) begin
                    state_d = ST_LAP_RUN;
`ifdef STOPWATCH_LAP_EN
                    lap_d   = time_q;
`endif
                end
            end
            ST_LAP_RUN: begin
                if (btn_start_stop) state_d = ST_STOP;
                else if (lap_pulse) state_d = ST_RUN;
            end
            ST_STOP: begin
                if (clear_eff) begin
                    state_d = ST_IDLE;
                    time_d  = '0;
                    presc_d = '0;
                    ovf_d   = 1'b0;
                end else if (btn_start_stop) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Snapshot scheduling: changes during an outstanding request coalesce into pending.
        set_pend = (tick && state_q != ST_LAP_RUN)
                 || ((state_q == ST_LAP_RUN) != (state_d == ST_LAP_RUN))
                 || clear_eff;
        issue     = pending_q && !req_q;
        pending_d = (pending_q && !issue) || set_pend;
        if (issue) begin
            req_d    = 1'b1;
            digits_d = src;
        end else if (req_q && disp_ack) begin
            req_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            time_q    <= '0;
            ovf_q     <= 1'b0;
            pending_q <= 1'b1;
            req_q     <= 1'b0;
            digits_q  <= '0;
`ifdef STOPWATCH_LAP_EN
            lap_q     <= '0;
`endif
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values of its peers.
            state_q   <= state_d;
            presc_q   <= presc_d;
            time_q    <= time_d;
            ovf_q     <= ovf_d;
            pending_q <= pending_d;
            req_q     <= req_d;
            digits_q  <= digits_d;
`ifdef STOPWATCH_LAP_EN
            lap_q     <= lap_d;
`endif
        end
    end

    assign disp_req    = req_q;
    assign disp_digits = digits_q;
    assign running     = (state_q == ST_RUN) || (state_q == ST_LAP_RUN);
    assign lap_hold    = (state_q == ST_LAP_RUN);
    assign overflow    = ovf_q;

endmodule
